// File: rtl/text_console_ctrl.sv
// Character output sequencer for the VGA text video memory.
// Tracks the cursor, writes printable codes and runs full-screen and line clear sweeps.
module text_console_ctrl #(
    parameter int unsigned COLS   = 50,
    parameter int unsigned ROWS   = 30,
    parameter int unsigned ADDR_W = 11,
    parameter logic [7:0]  BLANK  = 8'h20
) (
    input  logic              CLK_CPU,
    input  logic              resetn,
    input  logic              char_valid,
    input  logic [7:0]        char_data,
    output logic              char_ready,
    input  logic              clear_req,
    output logic              video_write_enable,
    output logic [ADDR_W-1:0] video_write_addr,
    output logic [7:0]        video_write_data,
    output logic [5:0]        cursor_col,
    output logic [4:0]        cursor_row,
    output logic              busy
);

    typedef enum logic [1:0] {StClearAll, StIdle, StLineClear} state_e;

    localparam logic [ADDR_W-1:0] ScreenSize = ADDR_W'(ROWS * COLS);
    localparam logic [ADDR_W-1:0] RowSize    = ADDR_W'(COLS);
    localparam logic [5:0]        LastCol    = 6'(COLS - 1);
    localparam logic [4:0]        LastRow    = 5'(ROWS - 1);

    state_e            state_q;
    logic [5:0]        col_q;
    logic [4:0]        row_q;
    logic [ADDR_W-1:0] line_base_q;
    logic [ADDR_W-1:0] cnt_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        data_q;

    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W-1:0] next_base;
    logic [4:0]        next_row;

    assign char_ready = (state_q == StIdle) && !clear_req;
    assign busy       = (state_q != StIdle);

    assign cur_addr  = line_base_q + ADDR_W'(col_q);
    assign next_row  = (row_q == LastRow) ? 5'd0 : row_q + 5'd1;
    assign next_base = (row_q == LastRow) ? '0 : line_base_q + RowSize;

    // Each sweep spends one extra cycle after its last write so char_ready only
    // rises once the final write has left the port.
    always_ff @(posedge CLK_CPU) begin
        if (!resetn) begin
            state_q     <= StClearAll;
            col_q       <= '0;
            row_q       <= '0;
            line_base_q <= '0;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            data_q      <= BLANK;
        end else begin
            we_q <= 1'b0;
            case (state_q)
                StClearAll: begin
                    if (cnt_q == ScreenSize) begin
                        state_q <= StIdle;
                        cnt_q   <= '0;
                    end else begin
                        we_q   <= 1'b1;
                        addr_q <= cnt_q;
                        data_q <= BLANK;
                        cnt_q  <= cnt_q + ADDR_W'(1);
                    end
                end
                StLineClear: begin
                    if (cnt_q == RowSize) begin
                        state_q <= StIdle;
                        cnt_q   <= '0;
                    end else begin
                        we_q   <= 1'b1;
                        addr_q <= line_base_q + cnt_q;
                        data_q <= BLANK;
                        cnt_q  <= cnt_q + ADDR_W'(1);
                    end
                end
                StIdle: begin
                    if (clear_req) begin
                        col_q       <= '0;
                        row_q       <= '0;
                        line_base_q <= '0;
                        cnt_q       <= '0;
                        state_q     <= StClearAll;
                    end else if (char_valid) begin
                        if (char_data >= 8'h20) begin
                            we_q   <= 1'b1;
                            addr_q <= cur_addr;
                            data_q <= char_data;
                            if (col_q == LastCol) begin
                                col_q       <= '0;
                                row_q       <= next_row;
                                line_base_q <= next_base;
                                cnt_q       <= '0;
                                state_q     <= StLineClear;
                            end else begin
                                col_q <= col_q + 6'd1;
                            end
                        end else if (char_data == 8'h0A) begin
                            // The first blank is issued here; the sweep covers the rest.
                            col_q       <= '0;
                            row_q       <= next_row;
                            line_base_q <= next_base;
                            we_q        <= 1'b1;
                            addr_q      <= next_base;
                            data_q      <= BLANK;
                            cnt_q       <= ADDR_W'(1);
                            state_q     <= StLineClear;
                        end else if (char_data == 8'h0D) begin
                            col_q <= '0;
                        end else if (char_data == 8'h08 && col_q != 6'd0) begin
                            col_q  <= col_q - 6'd1;
                            we_q   <= 1'b1;
                            addr_q <= cur_addr - ADDR_W'(1);
                            data_q <= BLANK;
                        end
                    end
                end
                default: state_q <= StClearAll;
            endcase
        end
    end

    assign video_write_enable = we_q;
    assign video_write_addr   = addr_q;
    assign video_write_data   = data_q;
    assign cursor_col         = col_q;
    assign cursor_row         = row_q;

endmodule

// File: tb/tb_text_console_ctrl.sv
// Randomized scoreboard bench for text_console_ctrl: a cursor/screen model queues
// expected memory writes, and a negedge monitor pops and compares them.
module tb_text_console_ctrl;

    localparam int COLS = 50;
    localparam int ROWS = 30;
    localparam logic [7:0] BLANK = 8'h20;

    typedef struct packed {
        logic [10:0] addr;
        logic [7:0]  data;
    } wr_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        char_valid = 1'b0;
    logic [7:0]  char_data = 8'h00;
    logic        char_ready;
    logic        clear_req = 1'b0;
    logic        video_write_enable;
    logic [10:0] video_write_addr;
    logic [7:0]  video_write_data;
    logic [5:0]  cursor_col;
    logic [4:0]  cursor_row;
    logic        busy;

    int checks = 0;
    int failures = 0;
    wr_t exp_q[$];
    int m_col = 0;
    int m_row = 0;

    text_console_ctrl dut (
        .CLK_CPU           (clk),
        .resetn            (resetn),
        .char_valid        (char_valid),
        .char_data         (char_data),
        .char_ready        (char_ready),
        .clear_req         (clear_req),
        .video_write_enable(video_write_enable),
        .video_write_addr  (video_write_addr),
        .video_write_data  (video_write_data),
        .cursor_col        (cursor_col),
        .cursor_row        (cursor_row),
        .busy              (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (video_write_enable === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write actual=%0h@%0d required=none",
                         video_write_data, video_write_addr);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("write_addr", 32'(video_write_addr), 32'(e.addr));
                check("write_data", 32'(video_write_data), 32'(e.data));
            end
        end
    end

    task automatic push_wr(input int addr, input logic [7:0] data);
        wr_t e;
        e.addr = 11'(addr);
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic push_row_blanks(input int row);
        for (int c = 0; c < COLS; c++) push_wr(row * COLS + c, BLANK);
    endtask

    // Screen semantics: returns whether a write appears the cycle after the handshake.
    task automatic model_char(input logic [7:0] c, output bit we_now);
        we_now = 1'b0;
        if (c >= 8'h20) begin
            push_wr(m_row * COLS + m_col, c);
            we_now = 1'b1;
            m_col++;
            if (m_col == COLS) begin
                m_col = 0;
                m_row = (m_row + 1) % ROWS;
                push_row_blanks(m_row);
            end
        end else if (c == 8'h0A) begin
            m_col = 0;
            m_row = (m_row + 1) % ROWS;
            push_row_blanks(m_row);
            we_now = 1'b1;
        end else if (c == 8'h0D) begin
            m_col = 0;
        end else if (c == 8'h08 && m_col > 0) begin
            m_col--;
            push_wr(m_row * COLS + m_col, BLANK);
            we_now = 1'b1;
        end
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!char_ready && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 5000) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout actual=low required=high");
        end
    endtask

    // Called at #1 after a clock edge; returns at #1 after the handshake edge.
    task automatic send(input logic [7:0] c);
        int n;
        bit we_now;
        wait_ready(n);
        char_valid = 1'b1;
        char_data  = c;
        model_char(c, we_now);
        @(posedge clk);
        #1;
        char_valid = 1'b0;
        check("cursor_col", 32'(cursor_col), 32'(m_col));
        check("cursor_row", 32'(cursor_row), 32'(m_row));
        check("write_strobe", 32'(video_write_enable), 32'(we_now));
    endtask

    // Entered with resetn low at #1 after an edge.
    task automatic sweep_after_reset();
        int bad = 0;
        for (int a = 0; a < ROWS * COLS; a++) push_wr(a, BLANK);
        resetn = 1'b1;
        check("pre_sweep_we", 32'(video_write_enable), 32'd0);
        for (int i = 0; i < ROWS * COLS; i++) begin
            @(posedge clk);
            #1;
            if (video_write_enable !== 1'b1 || char_ready !== 1'b0) bad++;
        end
        check("sweep_contiguous", 32'(bad), 32'd0);
        @(posedge clk);
        #1;
        check("post_sweep_we", 32'(video_write_enable), 32'd0);
        check("ready_after_sweep", 32'(char_ready), 32'd1);
        check("sweep_drained", 32'(exp_q.size()), 32'd0);
        m_col = 0;
        m_row = 0;
    endtask

    task automatic check_reset_values();
        check("rst_we", 32'(video_write_enable), 32'd0);
        check("rst_addr", 32'(video_write_addr), 32'd0);
        check("rst_data", 32'(video_write_data), 32'(BLANK));
        check("rst_col", 32'(cursor_col), 32'd0);
        check("rst_row", 32'(cursor_row), 32'd0);
        check("rst_ready", 32'(char_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd1);
    endtask

    initial begin
        int n;
        logic [7:0] c;

        repeat (3) @(posedge clk);
        #1;
        check_reset_values();
        sweep_after_reset();

        send(8'h41);
        send(8'h42);
        check("ab_col", 32'(cursor_col), 32'd2);
        send(8'h0D);

        for (int i = 0; i < COLS; i++) send(8'($urandom_range(32, 255)));
        wait_ready(n);
        check("wrap_ready_low", 32'(n), 32'd51);
        check("wrap_cursor", 32'({cursor_row, cursor_col}), 32'({5'd1, 6'd0}));

        send(8'h0A);
        wait_ready(n);
        check("lf_ready_low", 32'(n), 32'd50);
        for (int i = 0; i < 3; i++) send(8'($urandom_range(32, 255)));
        send(8'h08);
        check("bs_col", 32'(cursor_col), 32'd2);
        send(8'h08);
        send(8'h08);
        send(8'h08);
        check("bs_col0", 32'(cursor_col), 32'd0);
        send(8'h07);

        while (m_row != ROWS - 1) send(8'h0A);
        send(8'h0A);
        wait_ready(n);
        check("lf_wrap_ready_low", 32'(n), 32'd50);
        check("lf_wrap_row", 32'(cursor_row), 32'd0);
        for (int i = 0; i < 7; i++) send(8'($urandom_range(32, 255)));
        send(8'h0D);

        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 9))
                6: c = 8'h0A;
                7: c = 8'h0D;
                8: c = 8'h08;
                9: c = 8'($urandom_range(0, 31));
                default: c = 8'($urandom_range(32, 255));
            endcase
            send(c);
        end

        send(8'h0D);
        while (m_row != 4) send(8'h0A);
        for (int i = 0; i < 5; i++) send(8'($urandom_range(32, 255)));
        wait_ready(n);
        clear_req  = 1'b1;
        char_valid = 1'b1;
        char_data  = 8'h5A;
        for (int a = 0; a < ROWS * COLS; a++) push_wr(a, BLANK);
        m_col = 0;
        m_row = 0;
        #1;
        check("clear_blocks_ready", 32'(char_ready), 32'd0);
        @(posedge clk);
        #1;
        clear_req  = 1'b0;
        char_valid = 1'b0;
        check("clear_cursor", 32'({cursor_row, cursor_col}), 32'd0);
        check("clear_no_char_write", 32'(video_write_enable), 32'd0);
        check("clear_busy", 32'(busy), 32'd1);

        n = 0;
        while (!(video_write_enable === 1'b1 && video_write_addr == 11'd700) && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("reached_700", 32'(video_write_addr), 32'd700);
        resetn = 1'b0;
        @(posedge clk);
        #1;
        check_reset_values();
        exp_q.delete();
        sweep_after_reset();

        send(8'h31);
        check("final_col", 32'(cursor_col), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        check("final_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/text_console_ctrl.md
Name: text_console_ctrl

Overview:
Sequences CPU character output into the 1536x8 video memory that feeds the VGA text display. It accepts a byte stream over a valid/ready handshake and tracks a text cursor. It turns printable codes into video-memory writes and handles the control codes CR, LF and BS. It also runs the full-screen clear and single-line clear sweeps. It sits in the CPU clock domain and drives the memory write port directly (video_write_enable/addr/data).

Parameters:
COLS, 50, characters per text row (800 px / 16 px)
ROWS, 30, text rows in the display
ADDR_W, 11, video memory write address width
BLANK, 8'h20, code written by clear operations

Ports:
CLK_CPU  in  1  system clock; all logic on rising edge
resetn  in  1  synchronous, active-low reset
char_valid  in  1  character byte offered
char_data  in  8  character code
char_ready  out  1  block accepts char_data this cycle
clear_req  in  1  request full-screen clear (level, sampled in IDLE)
video_write_enable  out  1  write strobe to video memory
video_write_addr  out  11  write address, row*COLS+col
video_write_data  out  8  write data
cursor_col  out  6  current cursor column, 0..COLS-1
cursor_row  out  5  current cursor row, 0..ROWS-1
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset and clock: one clock, CLK_CPU. Reset is synchronous and active-low on resetn.
- Reset values: video_write_enable=0, video_write_addr=0, video_write_data=BLANK, cursor 0/0, state=CLEAR_ALL, char_ready=0, busy=1.
- Output registration: all write-port outputs are registered. A write decided in cycle N appears on the port in cycle N+1, for exactly one cycle.
- char_ready is combinational: (state==IDLE) && !clear_req. A handshake is char_valid && char_ready.
- Address arithmetic: no multiplier. Keep a line_base register (row*COLS) and adjust it by +/-COLS. Address = line_base + col. Maximum address is 1499, which fits ADDR_W.
- FSM states:
  - CLEAR_ALL: writes BLANK to addresses 0..ROWS*COLS-1, one per cycle. The first write is on the port in the cycle after the first cycle with resetn=1 (or after clear entry). After the last write, go to IDLE with cursor 0/0.
  - IDLE: accepts characters or a clear request.
  - LINE_CLEAR: writes BLANK to the COLS addresses of the current cursor row, one per cycle, then goes to IDLE.
- clear_req in IDLE: takes priority over a simultaneous char_valid (no char accepted). Cursor goes to 0/0 and the FSM enters CLEAR_ALL. clear_req is ignored outside IDLE.
- Code handling on handshake in IDLE:
  - 0x20..0xFF: write the code at the cursor and advance col.
    - If col was COLS-1: col=0 and row advances, wrapping ROWS-1 to 0.
    - On that wrap the FSM enters LINE_CLEAR next cycle. The char write is on the port in N+1 and the blanks follow in N+2..N+1+COLS.
  - 0x0A (LF): col=0, row advances with wrap, enter LINE_CLEAR. Blanks are on the port in N+1..N+COLS.
  - 0x0D (CR): col=0, no write, stay IDLE.
  - 0x08 (BS): if col>0, col decrements and BLANK is written at the new position. If col==0, no change and no write.
  - Any other code 0x00..0x1F: accepted and discarded.
- Throughput: in IDLE with no wrap, one character per cycle is accepted (back-to-back writes). char_ready is low throughout CLEAR_ALL and LINE_CLEAR.
- Reset mid-operation: any state returns to reset values. After reset the full clear restarts from address 0.
- Cursor outputs update on the cycle after handshake, together with the write.

Test Plan:
- Reset release: exactly 1500 writes of 0x20 at addresses 0..1499 in consecutive cycles. char_ready rises the cycle after the last write. No write enable occurs before or after the sweep.
- Send "A","B" back-to-back: write 0x41@0 then 0x42@1 in consecutive cycles. Final cursor_col=2, cursor_row=0.
- Send 50 printable chars from 0/0: last one writes @49, then 0x20@50..99. char_ready is low for 51 cycles. Final cursor 0/1.
- Cursor at row 29, send LF: 0x20 written @0..49 and cursor returns to 0/0. Then CR at col 7 sets col=0 with no write.
- Backspace at col 3, row 2: single write 0x20@102 and cursor_col=2. Backspace at col 0: no write and cursor unchanged. Code 0x07: accepted, no write.
- clear_req and char_valid both high in IDLE at cursor 5/4: char not accepted and a full 1500-write clear follows. Assert resetn=0 mid-clear at address 700: sweep restarts at 0.
